// File: rtl/riscv16_ctrl.sv
// riscv16_ctrl: multi-cycle control unit for the 16-bit core.
// Sequences fetch/decode/execute/memory/branch and drives the alu strobes,
// operand selects, register-file, PC and memory enables.
module riscv16_ctrl #(
  parameter int IW          = 16,
  parameter bit HALT_ON_IMM = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] mem_rdata,
  input  logic          mem_ready,
  input  logic          eq_out,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_addr_sel,
  output logic [IW-1:0] ir,
  output logic          ADD,
  output logic          NAND,
  output logic          PASS1,
  output logic          EQ,
  output logic [1:0]    src1_sel,
  output logic [1:0]    src2_sel,
  output logic          rf_we,
  output logic          rf_wdata_sel,
  output logic          pc_we,
  output logic          pc_sel,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BR, S_HALT
  } state_t;

  state_t     state;
  logic       eq_flag;
  logic       rst_cyc;   // first cycle after a sampled reset: everything quiet
  logic [2:0] op;
  logic [2:0] ra;
  logic       halt_req;
  logic       rf_wr;

  assign op       = ir[15:13];
  assign ra       = ir[12:10];
  assign halt_req = HALT_ON_IMM && (ir[6:0] != 7'd0);

  // State, instruction register and branch flag sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      eq_flag <= 1'b0;
      rst_cyc <= 1'b1;
    end else begin
      rst_cyc <= 1'b0;
      unique case (state)
        S_FETCH: begin
          // No request is issued in the reset cycle, so a ready there is ignored
          if (!rst_cyc && mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          unique case (op)
            3'b100, 3'b101: state <= S_MEM;
            3'b110: begin
              eq_flag <= eq_out;
              state   <= S_BR;
            end
            3'b111:  state <= halt_req ? S_HALT : S_FETCH;
            default: state <= S_FETCH;
          endcase
        end
        S_MEM:   if (mem_ready) state <= S_FETCH;
        S_BR:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state; fetch/memory enables follow mem_ready in the same cycle
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ADD          = 1'b0;
    NAND         = 1'b0;
    PASS1        = 1'b0;
    EQ           = 1'b0;
    src1_sel     = 2'd0;
    src2_sel     = 2'd0;
    rf_wr        = 1'b0;
    rf_wdata_sel = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    halted       = 1'b0;
    if (!rst_cyc) begin
      unique case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ADD      = 1'b1;
          src1_sel = 2'd1;
          src2_sel = 2'd2;
          pc_we    = mem_ready;
        end
        S_EXEC: begin
          unique case (op)
            3'b000: begin ADD = 1'b1; rf_wr = 1'b1; end
            3'b001: begin ADD = 1'b1; src2_sel = 2'd1; rf_wr = 1'b1; end
            3'b010: begin NAND = 1'b1; rf_wr = 1'b1; end
            3'b011: begin PASS1 = 1'b1; src1_sel = 2'd3; rf_wr = 1'b1; end
            3'b100, 3'b101: begin ADD = 1'b1; src2_sel = 2'd1; end
            3'b110: begin EQ = 1'b1; src1_sel = 2'd2; src2_sel = 2'd3; end
            default: begin
              PASS1    = 1'b1;
              src1_sel = 2'd1;
              if (!halt_req) begin
                rf_wr  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = 1'b1;
              end
            end
          endcase
        end
        S_MEM: begin
          // ALU keeps producing the effective address while waiting
          ADD          = 1'b1;
          src2_sel     = 2'd1;
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (op == 3'b100);
          if (op == 3'b101) begin
            rf_wr        = mem_ready;
            rf_wdata_sel = mem_ready;
          end
        end
        S_BR: begin
          ADD      = 1'b1;
          src1_sel = 2'd1;
          src2_sel = 2'd1;
          pc_we    = eq_flag;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign rf_we = rf_wr && (ra != 3'd0);

endmodule
